// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample width, ADC frame layout, sampler states.
package audio_pkg;

  localparam int unsigned SAMPLE_W       = 12;
  localparam int unsigned ADC_FRAME_BITS = 16;
  localparam int unsigned ADC_LEAD_ZEROS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    QUIET = 2'd2
  } adc_state_e;

  // Offset-binary ADC code to two's complement (subtract mid-scale).
  function automatic logic [SAMPLE_W-1:0] offset_to_twos(input logic [SAMPLE_W-1:0] raw);
    return {~raw[SAMPLE_W-1], raw[SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector for strobes synchronous to clock_in.
module rise_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock_in,
  input  logic reset,
  input  logic d,
  output logic rise_c
);

  logic d_q;

  // Previous-cycle copy of d; RESET_VAL suppresses a false edge at reset release.
  always_ff @(posedge clock_in) begin
    if (reset) d_q <= RESET_VAL;
    else       d_q <= d;
  end

  assign rise_c = d & ~d_q;

endmodule

// File: rtl/mic_adc_sampler.sv
// One SPI conversion of a 12-bit serial ADC per sample_clk rising edge.
module mic_adc_sampler
  import audio_pkg::*;
#(
  parameter int unsigned SCLK_DIV     = 4,
  parameter int unsigned QUIET_CYCLES = 8
) (
  input  logic                clock_in,
  input  logic                reset,
  input  logic                sample_clk,
  input  logic                adc_sdata,
  output logic                adc_cs_n,
  output logic                adc_sclk,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                format_err,
  output logic                overrun
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned BIT_W = 5;

  adc_state_e                state;
  logic [CNT_W-1:0]          half_cnt;
  logic [CNT_W-1:0]          quiet_cnt;
  logic [BIT_W-1:0]          bit_cnt;
  logic [ADC_FRAME_BITS-1:0] shift_q;
  logic [ADC_FRAME_BITS-1:0] shift_next;
  logic                      rise_c;
  logic                      half_wrap;
  logic                      last_bit;
  logic                      quiet_done;

  rise_detect #(.RESET_VAL(1'b1)) u_rise (
    .clock_in (clock_in),
    .reset    (reset),
    .d        (sample_clk),
    .rise_c   (rise_c)
  );

  assign shift_next = {shift_q[ADC_FRAME_BITS-2:0], adc_sdata};
  assign half_wrap  = (half_cnt == CNT_W'(SCLK_DIV - 1));
  assign last_bit   = (bit_cnt == BIT_W'(ADC_FRAME_BITS - 1));
  assign quiet_done = (quiet_cnt == CNT_W'(QUIET_CYCLES - 1));

  // Frame sequencer: chip select, SCLK generation, capture and result strobes.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state        <= IDLE;
      adc_cs_n     <= 1'b1;
      adc_sclk     <= 1'b1;
      half_cnt     <= '0;
      quiet_cnt    <= '0;
      bit_cnt      <= '0;
      shift_q      <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      format_err   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      format_err   <= 1'b0;
      overrun      <= rise_c && (state != IDLE);
      case (state)
        IDLE: begin
          adc_cs_n <= 1'b1;
          adc_sclk <= 1'b1;
          if (rise_c) begin
            state    <= SHIFT;
            adc_cs_n <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        SHIFT: begin
          if (half_wrap) begin
            half_cnt <= '0;
            adc_sclk <= ~adc_sclk;
            // sclk currently low: this toggle is a rising edge, so capture.
            if (!adc_sclk) begin
              shift_q <= shift_next;
              bit_cnt <= bit_cnt + BIT_W'(1);
              if (last_bit) begin
                state        <= QUIET;
                adc_cs_n     <= 1'b1;
                adc_sclk     <= 1'b1;
                quiet_cnt    <= '0;
                sample       <= offset_to_twos(shift_next[SAMPLE_W-1:0]);
                sample_valid <= 1'b1;
                format_err   <= |shift_next[ADC_FRAME_BITS-1 -: ADC_LEAD_ZEROS];
              end
            end
          end else begin
            half_cnt <= half_cnt + CNT_W'(1);
          end
        end
        QUIET: begin
          if (quiet_done) state <= IDLE;
          else            quiet_cnt <= quiet_cnt + CNT_W'(1);
        end
        default: begin
          state    <= IDLE;
          adc_cs_n <= 1'b1;
          adc_sclk <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mic_adc_sampler.sv
// Scoreboard bench for mic_adc_sampler with a behavioural serial ADC model.
module tb_mic_adc_sampler;

  localparam int unsigned SCLK_DIV     = 4;
  localparam int unsigned QUIET_CYCLES = 8;
  localparam int unsigned FRAME_CYC    = 32 * SCLK_DIV;

  typedef struct {
    logic [11:0] smp;
    logic        ferr;
    int          cyc;
  } exp_t;

  logic        clock_in = 1'b0;
  logic        reset;
  logic        sample_clk;
  logic        adc_sdata;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic [11:0] sample;
  logic        sample_valid;
  logic        format_err;
  logic        overrun;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   n_valid = 0;
  int   n_ovr = 0;
  int   last_ovr_cyc = -1;
  int   sclk_rises = 0;
  bit   count_en = 1'b0;
  int   bit_idx = 0;
  logic [15:0] adc_word = 16'h0000;
  exp_t sb[$];

  mic_adc_sampler #(.SCLK_DIV(SCLK_DIV), .QUIET_CYCLES(QUIET_CYCLES)) dut (
    .clock_in     (clock_in),
    .reset        (reset),
    .sample_clk   (sample_clk),
    .adc_sdata    (adc_sdata),
    .adc_cs_n     (adc_cs_n),
    .adc_sclk     (adc_sclk),
    .sample       (sample),
    .sample_valid (sample_valid),
    .format_err   (format_err),
    .overrun      (overrun)
  );

  always #5 clock_in = ~clock_in;

  always @(posedge clock_in) cyc <= cyc + 1;

  // ADC model: MSB first after cs_n falls, next bit after each sclk rise.
  always @(negedge adc_cs_n) bit_idx = 0;
  always @(posedge adc_sclk) begin
    bit_idx = bit_idx + 1;
    if (count_en) sclk_rises = sclk_rises + 1;
  end
  assign adc_sdata = (bit_idx < 16) ? adc_word[15 - bit_idx] : 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop the scoreboard on every sample_valid and compare.
  always @(negedge clock_in) begin
    if (!reset) begin
      if (overrun) begin
        n_ovr = n_ovr + 1;
        last_ovr_cyc = cyc;
      end
      if (format_err && !sample_valid) check("ferr_without_valid", 32'(format_err), 32'd0);
      if (sample_valid) begin
        exp_t e;
        n_valid = n_valid + 1;
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(sample_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("sample", 32'(sample), 32'(e.smp));
          check("format_err", 32'(format_err), 32'(e.ferr));
          check("valid_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock_in);
  endtask

  // Raise sample_clk so the next clock edge is E0; returns E0 cycle number.
  task automatic start_frame(input logic [15:0] word, output int e0);
    adc_word   = word;
    sample_clk = 1'b1;
    e0 = cyc + 1;
    @(negedge clock_in);
    check("cs_n_low_after_e0", 32'(adc_cs_n), 32'd0);
  endtask

  task automatic wait_valid(input int prev);
    int budget = 400;
    while (n_valid == prev && budget > 0) begin
      @(negedge clock_in);
      budget = budget - 1;
    end
    if (budget == 0) check("valid_timeout", 32'(n_valid), 32'(prev + 1));
  endtask

  task automatic run_frame(input logic [15:0] word, input logic [11:0] smp, input logic ferr);
    int e0;
    int prev;
    exp_t e;
    prev = n_valid;
    start_frame(word, e0);
    e.smp = smp; e.ferr = ferr; e.cyc = e0 + int'(FRAME_CYC);
    sb.push_back(e);
    wait_until(e0 + 4);
    sample_clk = 1'b0;
    wait_valid(prev);
    idle_cycles(int'(QUIET_CYCLES) + 4);
    check("sample_hold", 32'(sample), 32'(smp));
    check("cs_n_idle", 32'(adc_cs_n), 32'd1);
  endtask

  initial begin
    int e0;
    int prev_valid;
    int prev_ovr;
    exp_t e;

    // Reset with sample_clk high: no conversion may start at release.
    reset      = 1'b1;
    sample_clk = 1'b1;
    idle_cycles(5);
    reset = 1'b0;
    idle_cycles(20);
    check("rst_cs_n", 32'(adc_cs_n), 32'd1);
    check("rst_sclk", 32'(adc_sclk), 32'd1);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_ferr", 32'(format_err), 32'd0);
    check("rst_valid_count", 32'(n_valid), 32'd0);
    check("rst_overrun_count", 32'(n_ovr), 32'd0);
    sample_clk = 1'b0;
    idle_cycles(3);

    // Mid-scale word, counting sclk rising edges over the frame.
    sclk_rises = 0;
    count_en   = 1'b1;
    run_frame(16'h0800, 12'h000, 1'b0);
    count_en   = 1'b0;
    check("sclk_rises", 32'(sclk_rises), 32'd16);

    run_frame(16'h0FFF, 12'h7FF, 1'b0);
    run_frame(16'h0000, 12'h800, 1'b0);
    run_frame(16'h1ABC, 12'h2BC, 1'b1);

    // Second rise at E0+50: overrun pulse, frame unaffected.
    prev_valid = n_valid;
    prev_ovr   = n_ovr;
    start_frame(16'h0555, e0);
    e.smp = 12'hD55; e.ferr = 1'b0; e.cyc = e0 + int'(FRAME_CYC);
    sb.push_back(e);
    wait_until(e0 + 4);
    sample_clk = 1'b0;
    wait_until(e0 + 49);
    sample_clk = 1'b1;
    idle_cycles(3);
    sample_clk = 1'b0;
    wait_valid(prev_valid);
    idle_cycles(int'(QUIET_CYCLES) + 4);
    check("overrun_count", 32'(n_ovr - prev_ovr), 32'd1);
    check("overrun_cycle", 32'(last_ovr_cyc), 32'(e0 + 50));
    check("overrun_valid_count", 32'(n_valid - prev_valid), 32'd1);

    // Reset sampled at E0+60 aborts the frame.
    prev_valid = n_valid;
    start_frame(16'h0FFF, e0);
    wait_until(e0 + 4);
    sample_clk = 1'b0;
    wait_until(e0 + 59);
    reset = 1'b1;
    @(negedge clock_in);
    check("midrst_cs_n", 32'(adc_cs_n), 32'd1);
    check("midrst_sclk", 32'(adc_sclk), 32'd1);
    check("midrst_sample", 32'(sample), 32'd0);
    check("midrst_valid", 32'(sample_valid), 32'd0);
    reset = 1'b0;
    idle_cycles(200);
    check("midrst_no_valid", 32'(n_valid - prev_valid), 32'd0);
    run_frame(16'h0123, 12'h923, 1'b0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
